led_scan_scheduler: RTL
=======================

// Module: led_scan_scheduler
// PURPOSE
//  Sequences row scan and binary-coded-modulation (BCM) bit planes for a
//  shift-register LED panel. Sits between the framebuffer-fed shifter and the
//  panel control pins: requests one row/plane line shift, then blanks, latches
//  and drives the row address, with a weighted output-enable window per plane.
//  Shifting of the next line overlaps display of the current one.
// PARAMETERS
//  ROW_BITS   3   panel row address width (2**ROW_BITS scan rows)
//  PLANES     8   bit planes per row (plane index width = 3)
//  BASE_ON    16  OE window of plane 0 in clk cycles; plane p = BASE_ON<<p
//  BLANK_CYC  4   dark cycles before each latch (row-switch ghosting guard)
//  ON_W       16  on-time counter width; must hold BASE_ON<<(PLANES-1)
// PORTS
//  clk          in   1         system clock (the only clock)
//  reset        in   1         synchronous, active-high
//  enable       in   1         run scanning while high
//  brightness   in   8         global dim; 8'hFF = full on, 0 = dark
//  shift_req    out  1         level: shifter must shift shift_row/shift_plane
//  shift_row    out  ROW_BITS  row for requested shift
//  shift_plane  out  3         plane (data bit) for requested shift
//  shift_done   in   1         1-cycle pulse: requested line fully shifted
//  latch_out    out  1         panel latch, 1-cycle pulse
//  enable_out   out  1         panel OE, active-low (1 = dark)
//  addr_out     out  ROW_BITS  panel row address
//  frame_start  out  1         1-cycle pulse with latch of row 0 plane 0
//  busy         out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset values: shift_req=0, latch_out=0, enable_out=1, addr_out=0,
//   frame_start=0, busy=0, shift_row=0, shift_plane=0, state IDLE; pending
//   row/plane=0, done_seen=0, on_cnt=0. Reset aborts any handshake; a
//   shift_done arriving after reset is ignored.
//  Handshake: shift_req rises with stable shift_row/shift_plane, holds until
//   shift_done is sampled high, drops next cycle. shift_done while shift_req=0
//   is ignored. done_seen is a sticky flag set by shift_done, cleared on req.
//  States:
//   IDLE: enable_out=1. enable=1 -> issue req(0,0), go FILL.
//   FILL: wait done_seen -> BLANK (cnt=BLANK_CYC).
//   BLANK: enable_out=1 for BLANK_CYC cycles; then LATCH if enable, else IDLE.
//   LATCH (1 cycle): latch_out=1; addr_out<=pending row; on_cnt<=BASE_ON<<plane;
//    frame_start=1 iff pending=(0,0); advance pending: plane+1, at PLANES-1
//    wrap plane to 0 and row+1 (row wraps 2**ROW_BITS-1 -> 0); issue req for
//    new pending; go DISPLAY.
//   DISPLAY: on_cnt decrements each cycle to 0; while on_cnt!=0, enable_out=0
//    iff brightness==8'hFF or dither<brightness (free-running 8-bit dither);
//    when on_cnt==0 enable_out=1. Exit to BLANK when on_cnt==0 AND done_seen.
//    Slow shifter: panel stays dark (enable_out=1) until done; never extend OE.
//  Disable: enable low never truncates a DISPLAY window; BLANK exits to IDLE.
//   IDLE is entered only with no outstanding req (done_seen required).
//  Latency: enable rise -> shift_req next cycle; done -> latch BLANK_CYC+1 later.
//  Brightness may change any cycle; takes effect next cycle.
// TESTING
//  1 reset, brightness=FF, enable=1, shifter done 10 cyc after req -> one
//    latch_out pulse, addr_out=0, frame_start coincident, then exactly 16
//    cycles enable_out=0, 4 dark, next latch.
//  2 free-running fast shifter -> OE windows 16,32,64,...,2048 for planes 0..7,
//    addr_out increments after plane 7; shift_plane leads display by one plane.
//  3 shifter done 100 cyc after req during plane-0 window -> enable_out=0 for
//    16 cycles, stays 1 until done, +4 blank cycles, then latch.
//  4 run to row 7 plane 7 -> next latch addr_out=0, frame_start=1 one cycle;
//    brightness=0 -> enable_out never 0; brightness=80h -> 50% OE duty in window.
//  5 enable low mid-DISPLAY plane 3 -> window completes at 128 cycles, 4 blank,
//    no further latch_out, busy=0 only after pending shift_done.
//  6 reset asserted mid-DISPLAY with shift_req=1 -> next cycle all outputs at
//    reset values; shift_done pulse 2 cycles later causes no state change.

Source files
------------

// File: rtl/led_scan_scheduler.sv
// Row/bit-plane scan sequencer for a shift-register LED panel: requests line
// shifts, then blanks, latches and opens a BCM-weighted OE window per plane.
module led_scan_scheduler #(
    parameter int ROW_BITS  = 3,
    parameter int PLANES    = 8,
    parameter int BASE_ON   = 16,
    parameter int BLANK_CYC = 4,
    parameter int ON_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          brightness,
    output logic                shift_req,
    output logic [ROW_BITS-1:0] shift_row,
    output logic [2:0]          shift_plane,
    input  logic                shift_done,
    output logic                latch_out,
    output logic                enable_out,
    output logic [ROW_BITS-1:0] addr_out,
    output logic                frame_start,
    output logic                busy
);
    localparam int BC_W = $clog2(BLANK_CYC + 1);

    typedef enum logic [2:0] {IDLE, FILL, BLANK, LATCH, DISPLAY} state_t;

    state_t              state, state_n;
    logic [BC_W-1:0]     blank_cnt, blank_cnt_n;
    logic [ON_W-1:0]     on_cnt, on_cnt_n;
    logic [ROW_BITS-1:0] pend_row, pend_row_n;
    logic [2:0]          pend_plane, pend_plane_n;
    logic                done_seen, done_seen_n;
    logic [7:0]          dither;

    logic                shift_req_n, latch_n, enable_out_n, frame_n, busy_n, issue;
    logic [ROW_BITS-1:0] shift_row_n, addr_n;
    logic [2:0]          shift_plane_n;

    always_comb begin
        state_n       = state;
        blank_cnt_n   = blank_cnt;
        on_cnt_n      = on_cnt;
        pend_row_n    = pend_row;
        pend_plane_n  = pend_plane;
        done_seen_n   = done_seen;
        shift_req_n   = shift_req;
        shift_row_n   = shift_row;
        shift_plane_n = shift_plane;
        addr_n        = addr_out;
        latch_n       = 1'b0;
        frame_n       = 1'b0;
        issue         = 1'b0;

        // shift_done only counts while a request is outstanding
        if (shift_req && shift_done) begin
            shift_req_n = 1'b0;
            done_seen_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (enable) begin
                    pend_row_n   = '0;
                    pend_plane_n = '0;
                    issue        = 1'b1;
                    state_n      = FILL;
                end
            end
            FILL: begin
                if (done_seen_n) begin
                    state_n     = BLANK;
                    blank_cnt_n = BC_W'(BLANK_CYC);
                end
            end
            BLANK: begin
                if (blank_cnt > BC_W'(1)) begin
                    blank_cnt_n = blank_cnt - 1'b1;
                end else if (enable) begin
                    // latch actions register on entry so they show during LATCH
                    state_n  = LATCH;
                    latch_n  = 1'b1;
                    addr_n   = pend_row;
                    on_cnt_n = ON_W'(BASE_ON) << pend_plane;
                    frame_n  = (pend_row == '0) && (pend_plane == '0);
                    if (pend_plane == 3'(PLANES - 1)) begin
                        pend_plane_n = '0;
                        pend_row_n   = pend_row + 1'b1;
                    end else begin
                        pend_plane_n = pend_plane + 1'b1;
                    end
                    issue = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            LATCH: state_n = DISPLAY;
            DISPLAY: begin
                if (on_cnt != '0)
                    on_cnt_n = on_cnt - 1'b1;
                // a late shifter keeps the panel dark; the window is never stretched
                if (on_cnt_n == '0 && done_seen_n) begin
                    state_n     = BLANK;
                    blank_cnt_n = BC_W'(BLANK_CYC);
                end
            end
            default: state_n = IDLE;
        endcase

        if (issue) begin
            shift_req_n   = 1'b1;
            done_seen_n   = 1'b0;
            shift_row_n   = pend_row_n;
            shift_plane_n = pend_plane_n;
        end

        enable_out_n = !((state_n == DISPLAY) && (on_cnt_n != '0) &&
                         ((brightness == 8'hFF) || (dither < brightness)));
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            blank_cnt   <= '0;
            on_cnt      <= '0;
            pend_row    <= '0;
            pend_plane  <= '0;
            done_seen   <= 1'b0;
            dither      <= '0;
            shift_req   <= 1'b0;
            shift_row   <= '0;
            shift_plane <= '0;
            latch_out   <= 1'b0;
            enable_out  <= 1'b1;
            addr_out    <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            blank_cnt   <= blank_cnt_n;
            on_cnt      <= on_cnt_n;
            pend_row    <= pend_row_n;
            pend_plane  <= pend_plane_n;
            done_seen   <= done_seen_n;
            dither      <= dither + 1'b1;
            shift_req   <= shift_req_n;
            shift_row   <= shift_row_n;
            shift_plane <= shift_plane_n;
            latch_out   <= latch_n;
            enable_out  <= enable_out_n;
            addr_out    <= addr_n;
            frame_start <= frame_n;
            busy        <= busy_n;
        end
    end
endmodule
